// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Optional feature macro: ALU_RESULT_PARITY_FLAG_EN (adds parity flag bit 3).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_INC = 3'b110,
        OP_DEC = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_P = 3;

`ifdef ALU_RESULT_PARITY_FLAG_EN
    localparam int unsigned FW = 4;
`else
    localparam int unsigned FW = 3;
`endif

    // Arithmetic ops are the only ones whose carry/borrow is meaningful.
    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generator for one ALU result.
// Optional feature macro: ALU_RESULT_PARITY_FLAG_EN (adds parity flag).
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_cout,
    input  logic [2:0]       in_op,
    output logic [FW-1:0]    flags_c
);

    // Derive {P,C,N,Z} from the incoming result.
    always_comb begin
        flags_c         = '0;
        flags_c[FLAG_Z] = (in_res == '0);
        flags_c[FLAG_N] = in_res[WIDTH-1];
        flags_c[FLAG_C] = is_arith(op_e'(in_op)) & in_cout;
`ifdef ALU_RESULT_PARITY_FLAG_EN
        flags_c[FLAG_P] = ^in_res;
`endif
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered 2-entry in-order result queue between the ALU and write-back.
// Optional feature macro: ALU_RESULT_PARITY_FLAG_EN (4-bit flags with parity).
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_cout,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [2:0]       out_op,
    output logic [FW-1:0]    out_flags,
    output logic [15:0]      ops_done
);

    occ_e             occ;
    occ_e             occ_nxt;
    logic             push;
    logic             pop;
    logic [FW-1:0]    push_flags_c;
    logic [WIDTH-1:0] tail_res;
    logic [2:0]       tail_op;
    logic [FW-1:0]    tail_flags;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .in_res  (in_res),
        .in_cout (in_cout),
        .in_op   (in_op),
        .flags_c (push_flags_c)
    );

    // Handshakes use only registered ready/valid, so no out_ready -> in_ready path.
    always_comb begin
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
    end

    // Next occupancy.
    always_comb begin
        occ_nxt = occ;
        case (occ)
            OCC_EMPTY: if (push) occ_nxt = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_nxt = OCC_FULL;
                else if (!push && pop) occ_nxt = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_nxt = OCC_ONE;
            default:   occ_nxt = OCC_EMPTY;
        endcase
    end

    // Occupancy FSM, head/tail storage and saturating pop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= OCC_EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_op     <= '0;
            out_flags  <= '0;
            tail_res   <= '0;
            tail_op    <= '0;
            tail_flags <= '0;
            ops_done   <= '0;
        end else begin
            occ       <= occ_nxt;
            in_ready  <= (32'(occ_nxt) < DEPTH);
            out_valid <= (occ_nxt != OCC_EMPTY);
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        out_res   <= in_res;
                        out_op    <= in_op;
                        out_flags <= push_flags_c;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        out_res   <= in_res;
                        out_op    <= in_op;
                        out_flags <= push_flags_c;
                    end else if (push) begin
                        tail_res   <= in_res;
                        tail_op    <= in_op;
                        tail_flags <= push_flags_c;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        out_res   <= tail_res;
                        out_op    <= tail_op;
                        out_flags <= tail_flags;
                    end
                end
                default: ;
            endcase
            if (pop && (ops_done != 16'hFFFF)) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 4;
`ifdef ALU_RESULT_PARITY_FLAG_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_res;
    logic             in_cout;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [2:0]       out_op;
    logic [FW-1:0]    out_flags;
    logic [15:0]      ops_done;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_cout   (in_cout),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_op    (out_op),
        .out_flags (out_flags),
        .ops_done  (ops_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected flag word; parity bit only exists in the parity build.
    function automatic logic [31:0] fl(input logic c, input logic n, input logic z, input logic p);
        return 32'({p & PAR_EN, c, n, z});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic [2:0] op, input logic c);
        in_valid = v;
        in_res   = r;
        in_op    = op;
        in_cout  = c;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 3'b000, 1'b0);

        // Reset
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_ops_done",  32'(ops_done),  32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_out_res",   32'(out_res),   32'd0);
        rst = 1'b0;

        // Single NOT push, popped immediately
        out_ready = 1'b1;
        drive(1'b1, 4'hF, 3'b101, 1'b1);
        step();
        drive(1'b0, 4'h0, 3'b000, 1'b0);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_res",   32'(out_res),   32'hF);
        check("single_op",    32'(out_op),    32'd5);
        check("single_flags", 32'(out_flags), fl(1'b0, 1'b1, 1'b0, 1'b0));
        step();
        check("single_ops_done", 32'(ops_done),  32'd1);
        check("single_empty",    32'(out_valid), 32'd0);

        // Fill and back-pressure
        out_ready = 1'b0;
        drive(1'b1, 4'h0, 3'b000, 1'b1);
        step();
        check("fill1_in_ready", 32'(in_ready), 32'd1);
        check("fill1_res",      32'(out_res),  32'h0);
        check("fill1_flags",    32'(out_flags), fl(1'b1, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 4'h8, 3'b001, 1'b0);
        step();
        check("fill2_in_ready", 32'(in_ready),  32'd0);
        check("fill2_head_res", 32'(out_res),   32'h0);
        check("fill2_flags",    32'(out_flags), fl(1'b1, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 4'h3, 3'b010, 1'b1);
        step();
        step();
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_head_res", 32'(out_res),  32'h0);
        out_ready = 1'b1;
        step();
        check("drain1_res",   32'(out_res),   32'h8);
        check("drain1_op",    32'(out_op),    32'd1);
        check("drain1_flags", 32'(out_flags), fl(1'b0, 1'b1, 1'b0, 1'b1));
        check("drain1_ops",   32'(ops_done),  32'd2);
        step();
        drive(1'b0, 4'h0, 3'b000, 1'b0);
        check("drain2_res",   32'(out_res),   32'h3);
        check("drain2_flags", 32'(out_flags), fl(1'b0, 1'b0, 1'b0, 1'b0));
        check("drain2_valid", 32'(out_valid), 32'd1);
        check("drain2_ops",   32'(ops_done),  32'd3);
        step();
        check("drain3_valid", 32'(out_valid), 32'd0);
        check("drain3_ops",   32'(ops_done),  32'd4);

        // Continuous stream 1..9 at full throughput
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 4'(i), 3'b000, 1'b0);
            step();
            check($sformatf("stream_res_%0d", i), 32'(out_res),   32'(i));
            check($sformatf("stream_vld_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("stream_rdy_%0d", i), 32'(in_ready),  32'd1);
        end
        drive(1'b0, 4'h0, 3'b000, 1'b0);
        step();
        check("stream_ops_done", 32'(ops_done),  32'd13);
        check("stream_empty",    32'(out_valid), 32'd0);

        // Reset with a full queue
        out_ready = 1'b0;
        drive(1'b1, 4'h5, 3'b110, 1'b0);
        step();
        drive(1'b1, 4'h7, 3'b111, 1'b0);
        step();
        check("mrst_full", 32'(in_ready), 32'd0);
        drive(1'b0, 4'h0, 3'b000, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid",    32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready),  32'd1);
        check("mrst_ops_done", 32'(ops_done),  32'd0);
        check("mrst_res",      32'(out_res),   32'd0);
        drive(1'b1, 4'h6, 3'b100, 1'b1);
        step();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_res",   32'(out_res),   32'h6);
        check("post_rst_flags", 32'(out_flags), fl(1'b0, 1'b0, 1'b0, 1'b0));

        // Parity-odd result replaces head while popping
        out_ready = 1'b1;
        drive(1'b1, 4'h7, 3'b011, 1'b1);
        step();
        check("par_res",   32'(out_res),   32'h7);
        check("par_flags", 32'(out_flags), fl(1'b0, 1'b0, 1'b0, 1'b1));
        check("par_ops",   32'(ops_done),  32'd1);

        // Saturation: keep streaming so every cycle pops
        for (int i = 0; i < 65533; i++) step();
        check("sat_fffe", 32'(ops_done), 32'hFFFE);
        step();
        check("sat_ffff", 32'(ops_done), 32'hFFFF);
        for (int i = 0; i < 5; i++) step();
        check("sat_hold", 32'(ops_done), 32'hFFFF);
        check("sat_flow", 32'(in_ready), 32'd1);
        drive(1'b0, 4'h0, 3'b000, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
